// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate format codes for the decode-path
// immediate generator.
package imm_pkg;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_SH   = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // JALR is excluded: its base register is not known at this stage.
    function automatic logic is_pc_rel(input fmt_e fmt, input logic [6:0] opcode);
        return (fmt == FMT_B) || (fmt == FMT_J) || (opcode == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream handshake bundle of the immediate-generation stage.
// The stage itself uses the slave view; its environment uses the master view.
interface imm_decode_stage_if import imm_pkg::*; #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );
endinterface

// File: rtl/imm_fmt_decode.sv
// Combinational immediate classifier: instruction word -> extended immediate,
// format code and unsupported-encoding flag.
module imm_fmt_decode import imm_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [5:0]      shamt;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3[1:0] == 2'b01);
    assign shamt    = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

    assign imm_i = XLEN'(signed'(instr[31:20]));
    assign imm_s = XLEN'(signed'({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'(signed'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_j = XLEN'(signed'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_u = XLEN'(signed'({instr[31:12], 12'b0}));

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            unique case (opcode)
                OPC_LOAD, OPC_JALR: begin
                    fmt = FMT_I;
                    imm = imm_i;
                end
                OPC_OP_IMM: begin
                    if (is_shift) begin
                        fmt     = FMT_SH;
                        imm     = XLEN'(shamt);
                        illegal = (XLEN == 32) && instr[25];
                    end else begin
                        fmt = FMT_I;
                        imm = imm_i;
                    end
                end
                OPC_OP_IMM_32: begin
                    if (XLEN == 32) begin
                        illegal = 1'b1;
                    end else if (is_shift) begin
                        fmt     = FMT_SH;
                        imm     = XLEN'(instr[24:20]);
                        illegal = instr[25];
                    end else begin
                        fmt = FMT_I;
                        imm = imm_i;
                    end
                end
                OPC_STORE: begin
                    fmt = FMT_S;
                    imm = imm_s;
                end
                OPC_BRANCH: begin
                    fmt = FMT_B;
                    imm = imm_b;
                end
                OPC_JAL: begin
                    fmt = FMT_J;
                    imm = imm_j;
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt = FMT_U;
                    imm = imm_u;
                end
                OPC_SYSTEM: begin
                    if (funct3[2]) begin
                        fmt = FMT_Z;
                        imm = XLEN'(instr[19:15]);
                    end
                end
                OPC_OP, OPC_FENCE: ;
                default: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage: decode + target adder ahead of an
// output register backed by a one-entry skid buffer.
module imm_decode_stage import imm_pkg::*; #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    imm_decode_stage_if.slave bus
);
    logic [XLEN-1:0] dec_imm, dec_target;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    logic            out_valid_q, skid_valid_q;
    logic [XLEN-1:0] out_imm_q, out_target_q, skid_imm_q, skid_target_q;
    fmt_e            out_fmt_q, skid_fmt_q;
    logic            out_illegal_q, skid_illegal_q;

    logic accept, out_free, load_out_new, load_skid, skid_to_out;

    imm_fmt_decode #(.XLEN(XLEN)) u_fmt_decode (
        .instr   (bus.in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec_target = bus.in_pc + (is_pc_rel(dec_fmt, bus.in_instr[6:0]) ? dec_imm : XLEN'(4));

    // in_ready depends only on the skid flag, never on out_ready.
    assign accept       = bus.in_valid & ~skid_valid_q;
    assign out_free     = ~out_valid_q | bus.out_ready;
    assign load_out_new = ~flush & accept & out_free;
    assign load_skid    = ~flush & accept & ~out_free;
    assign skid_to_out  = ~flush & skid_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            out_imm_q     <= '0;
            out_fmt_q     <= FMT_NONE;
            out_target_q  <= '0;
            out_illegal_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            if (skid_to_out) begin
                out_valid_q   <= 1'b1;
                skid_valid_q  <= 1'b0;
                out_imm_q     <= skid_imm_q;
                out_fmt_q     <= skid_fmt_q;
                out_target_q  <= skid_target_q;
                out_illegal_q <= skid_illegal_q;
            end else if (load_out_new) begin
                out_valid_q   <= 1'b1;
                out_imm_q     <= dec_imm;
                out_fmt_q     <= dec_fmt;
                out_target_q  <= dec_target;
                out_illegal_q <= dec_illegal;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (load_skid) begin
                skid_valid_q <= 1'b1;
            end
        end
    end

    // NOTE: skid payload has no reset; it is only read while skid_valid_q is set.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_imm_q     <= dec_imm;
            skid_fmt_q     <= dec_fmt;
            skid_target_q  <= dec_target;
            skid_illegal_q <= dec_illegal;
        end
    end

    assign bus.in_ready    = ~skid_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_fmt     = out_fmt_q;
    assign bus.out_target  = out_target_q;
    assign bus.out_illegal = out_illegal_q;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: XLEN=32 instance under flow control,
// flush and reset; XLEN=64 instance for wide-immediate decoding.
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush64 = 1'b0;
    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) bus32 ();
    imm_decode_stage_if #(.XLEN(64)) bus64 ();

    imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush),   .bus(bus32));
    imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush64), .bus(bus64));

    typedef struct {
        logic [63:0] imm;
        fmt_e        fmt;
        logic        ill;
        logic [63:0] tgt;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        exp_t        e;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    exp_t        q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_imm, prev_tgt;
    fmt_e        prev_fmt;
    logic        prev_ill;

    // Reference model: immediates assembled arithmetically from instruction fields.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
        exp_t   e;
        longint s;
        logic   pcrel;
        logic   shift_op;
        s        = longint'(signed'(ins));
        e.imm    = 64'd0;
        e.fmt    = FMT_NONE;
        e.ill    = 1'b0;
        pcrel    = 1'b0;
        shift_op = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
        if (ins[1:0] != 2'b11) e.ill = 1'b1;
        else begin
            case (ins[6:0])
                7'h03, 7'h67: begin e.fmt = FMT_I; e.imm = s >>> 20; end
                7'h13: begin
                    if (shift_op) begin
                        e.fmt = FMT_SH;
                        e.imm = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
                        e.ill = (xlen == 32) && ins[25];
                    end else begin e.fmt = FMT_I; e.imm = s >>> 20; end
                end
                7'h1B: begin
                    if (xlen == 32) e.ill = 1'b1;
                    else if (shift_op) begin
                        e.fmt = FMT_SH; e.imm = 64'(ins[24:20]); e.ill = ins[25];
                    end else begin e.fmt = FMT_I; e.imm = s >>> 20; end
                end
                7'h23: begin e.fmt = FMT_S; e.imm = (s >>> 25) * 32 + longint'(ins[11:7]); end
                7'h63: begin
                    e.fmt = FMT_B; pcrel = 1'b1;
                    e.imm = (s >>> 31) * 4096 + longint'(ins[7]) * 2048
                          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                end
                7'h6F: begin
                    e.fmt = FMT_J; pcrel = 1'b1;
                    e.imm = (s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                end
                7'h37: begin e.fmt = FMT_U; e.imm = (s >>> 12) * 4096; end
                7'h17: begin e.fmt = FMT_U; e.imm = (s >>> 12) * 4096; pcrel = 1'b1; end
                7'h73: if (ins[14]) begin e.fmt = FMT_Z; e.imm = 64'(ins[19:15]); end
                7'h33, 7'h0F: ;
                default: e.ill = 1'b1;
            endcase
        end
        e.tgt = pc + (pcrel ? e.imm : 64'd4);
        if (xlen == 32) begin
            e.imm = e.imm & 64'hFFFF_FFFF;
            e.tgt = e.tgt & 64'hFFFF_FFFF;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [12];
        logic [31:0] ins;
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h0F};
        ins = $urandom;
        if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 11)];
        return ins;
    endfunction

    // One cycle on the XLEN=32 instance: check outputs against the queue model,
    // then drive the inputs for the coming rising edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, output logic accepted);
        exp_t e;
        int   n;
        n = q.size();
        vectors++;
        if (bus32.out_valid !== (n > 0)) begin
            miscompares++;
            $display("FAIL out_valid: got %b expected %b", bus32.out_valid, (n > 0));
        end
        vectors++;
        if (bus32.in_ready !== (n < 2)) begin
            miscompares++;
            $display("FAIL in_ready: got %b expected %b", bus32.in_ready, (n < 2));
        end
        if (n > 0) begin
            e = q[0];
            vectors++;
            if ({bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal} !==
                {e.imm[31:0], e.fmt, e.tgt[31:0], e.ill}) begin
                miscompares++;
                $display("FAIL stream data: got imm=%h fmt=%0d tgt=%h ill=%b expected imm=%h fmt=%0d tgt=%h ill=%b",
                         bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal,
                         e.imm[31:0], e.fmt, e.tgt[31:0], e.ill);
            end
        end
        if (prev_stall) begin
            vectors++;
            if ({bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal} !==
                {prev_imm, prev_fmt, prev_tgt, prev_ill}) begin
                miscompares++;
                $display("FAIL stall hold: got imm=%h tgt=%h expected imm=%h tgt=%h",
                         bus32.out_imm, bus32.out_target, prev_imm, prev_tgt);
            end
        end
        prev_stall = (n > 0) && !rdy && !fl;
        prev_imm   = bus32.out_imm;
        prev_fmt   = bus32.out_fmt;
        prev_tgt   = bus32.out_target;
        prev_ill   = bus32.out_illegal;

        bus32.in_valid  = v;
        bus32.in_instr  = ins;
        bus32.in_pc     = pc;
        bus32.out_ready = rdy;
        flush           = fl;

        accepted = v && (n < 2) && !fl;
        if (fl) q.delete();
        else begin
            if (rdy && n > 0) void'(q.pop_front());
            if (accepted) q.push_back(ref_decode(ins, {32'd0, pc}, 32));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_pc = '0; bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;
        #1;
        vectors++;
        if ({bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal, bus32.in_ready} !==
            {1'b0, 32'd0, FMT_NONE, 32'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset32: got v=%b imm=%h fmt=%0d tgt=%h ill=%b rdy=%b expected all zero, rdy=1",
                     bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal, bus32.in_ready);
        end
        vectors++;
        if ({bus64.out_valid, bus64.out_imm, bus64.out_fmt, bus64.out_target, bus64.out_illegal, bus64.in_ready} !==
            {1'b0, 64'd0, FMT_NONE, 64'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset64: got v=%b imm=%h tgt=%h rdy=%b expected zeros, rdy=1",
                     bus64.out_valid, bus64.out_imm, bus64.out_target, bus64.in_ready);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL after_release: got v=%b rdy=%b expected v=0 rdy=1", bus32.out_valid, bus32.in_ready);
        end
    endtask

    task automatic test_directed32();
        vec_t tab[10];
        tab[0] = '{32'hFE000CE3, 64'h100,  '{64'hFFFFFFF8, FMT_B,    1'b0, 64'h000000F8}};
        tab[1] = '{32'hFE000CE3, 64'h0,    '{64'hFFFFFFF8, FMT_B,    1'b0, 64'hFFFFFFF8}};
        tab[2] = '{32'h001000EF, 64'h1000, '{64'h00000800, FMT_J,    1'b0, 64'h00001800}};
        tab[3] = '{32'h123452B7, 64'h40,   '{64'h12345000, FMT_U,    1'b0, 64'h00000044}};
        tab[4] = '{32'h12345097, 64'h1000, '{64'h12345000, FMT_U,    1'b0, 64'h12346000}};
        tab[5] = '{32'h300FD073, 64'h200,  '{64'h0000001F, FMT_Z,    1'b0, 64'h00000204}};
        tab[6] = '{32'h0000007F, 64'h300,  '{64'h00000000, FMT_NONE, 1'b1, 64'h00000304}};
        tab[7] = '{32'h02009093, 64'h400,  '{64'h00000000, FMT_SH,   1'b1, 64'h00000404}};
        tab[8] = '{32'hFFC080E7, 64'h500,  '{64'hFFFFFFFC, FMT_I,    1'b0, 64'h00000504}};
        tab[9] = '{32'h00000001, 64'h600,  '{64'h00000000, FMT_NONE, 1'b1, 64'h00000604}};
        bus32.out_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                vectors++;
                if ({bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal} !==
                    {1'b1, tab[k-1].e.imm[31:0], tab[k-1].e.fmt, tab[k-1].e.tgt[31:0], tab[k-1].e.ill}) begin
                    miscompares++;
                    $display("FAIL directed32[%0d]: got v=%b imm=%h fmt=%0d tgt=%h ill=%b expected imm=%h fmt=%0d tgt=%h ill=%b",
                             k - 1, bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal,
                             tab[k-1].e.imm[31:0], tab[k-1].e.fmt, tab[k-1].e.tgt[31:0], tab[k-1].e.ill);
                end
            end
            if (k < 10) begin
                bus32.in_valid = 1'b1;
                bus32.in_instr = tab[k].ins;
                bus32.in_pc    = tab[k].pc[31:0];
            end else bus32.in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_xlen64();
        vec_t tab[4];
        vec_t cur, prev;
        logic have = 1'b0;
        tab[0] = '{32'hFFF13083, 64'h8000_0000_0000_0000, '{64'hFFFF_FFFF_FFFF_FFFF, FMT_I,  1'b0, 64'h8000_0000_0000_0004}};
        tab[1] = '{32'h03F09093, 64'h10,                  '{64'd63,                  FMT_SH, 1'b0, 64'h14}};
        tab[2] = '{32'h80000097, 64'h1000,                '{64'hFFFF_FFFF_8000_0000, FMT_U,  1'b0, 64'hFFFF_FFFF_8000_1000}};
        tab[3] = '{32'hFFF0809B, 64'h20,                  '{64'hFFFF_FFFF_FFFF_FFFF, FMT_I,  1'b0, 64'h24}};
        bus64.out_ready = 1'b1;
        for (int k = 0; k <= 150; k++) begin
            if (have) begin
                vectors++;
                if ({bus64.out_valid, bus64.out_imm, bus64.out_fmt, bus64.out_target, bus64.out_illegal} !==
                    {1'b1, prev.e.imm, prev.e.fmt, prev.e.tgt, prev.e.ill}) begin
                    miscompares++;
                    $display("FAIL xlen64 ins=%h: got v=%b imm=%h fmt=%0d tgt=%h ill=%b expected imm=%h fmt=%0d tgt=%h ill=%b",
                             prev.ins, bus64.out_valid, bus64.out_imm, bus64.out_fmt, bus64.out_target, bus64.out_illegal,
                             prev.e.imm, prev.e.fmt, prev.e.tgt, prev.e.ill);
                end
            end
            have = (k < 150);
            if (have) begin
                if (k < 4) cur = tab[k];
                else begin
                    cur.ins = rand_instr();
                    cur.pc  = {$urandom, $urandom};
                    cur.e   = ref_decode(cur.ins, cur.pc, 64);
                end
                prev = cur;
                bus64.in_valid = 1'b1;
                bus64.in_instr = cur.ins;
                bus64.in_pc    = cur.pc;
            end else bus64.in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        int   stalled_accepts = 0;
        logic acc;
        logic ready_seen;
        logic rdy;
        logic done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            rdy        = !(c >= 2 && c <= 4);
            ready_seen = bus32.in_ready;
            step(sent < 6, rand_instr(), $urandom, rdy, 1'b0, acc);
            if (acc) sent++;
            if (ready_seen && sent < 7 && c >= 2 && c <= 4 && acc) stalled_accepts++;
            if (sent == 6 && q.size() == 0) begin
                step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
                done = 1'b1;
                break;
            end
        end
        vectors++;
        if (!done || stalled_accepts != 1) begin
            miscompares++;
            $display("FAIL backpressure: got done=%b stalled_accepts=%0d expected done=1 stalled_accepts=1",
                     done, stalled_accepts);
        end
    endtask

    task automatic test_flush();
        logic acc;
        step(1'b1, 32'h001000EF, 32'h1000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h123452B7, 32'h40,   1'b0, 1'b0, acc);
        vectors++;
        if (bus32.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_setup in_ready: got %b expected 0", bus32.in_ready);
        end
        step(1'b1, 32'hFE000CE3, 32'h100, 1'b0, 1'b1, acc);
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
        step(1'b1, 32'h300FD073, 32'h200, 1'b1, 1'b0, acc);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_random_stream();
        logic acc;
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, acc);
        end
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_async_reset();
        logic acc;
        for (int c = 0; c < 5; c++) step(1'b1, rand_instr(), $urandom, c < 2, 1'b0, acc);
        bus32.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal, bus32.in_ready} !==
            {1'b0, 32'd0, FMT_NONE, 32'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b imm=%h fmt=%0d tgt=%h ill=%b rdy=%b expected all zero, rdy=1",
                     bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_target, bus32.out_illegal, bus32.in_ready);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        q.delete();
        prev_stall = 1'b0;
        step(1'b1, 32'hFE000CE3, 32'h100, 1'b1, 1'b0, acc);
        vectors++;
        if ({bus32.out_valid, bus32.out_target} !== {1'b1, 32'h000000F8}) begin
            miscompares++;
            $display("FAIL post_reset latency: got v=%b tgt=%h expected v=1 tgt=000000f8",
                     bus32.out_valid, bus32.out_target);
        end
        repeat (2) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed32();
        test_xlen64();
        test_backpressure();
        test_flush();
        test_random_stream();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
